uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter.
- Data width, parity mode and stop-bit count are set at elaboration.
- A one-entry holding register with a valid/ready handshake lets the next byte be accepted while the current frame is on the line, so frames can go out back-to-back with no idle gap.
- Sits between a byte producer (CPU bridge or FIFO) and the TX pin. Target clock 50 MHz.

Parameters:
- CLOCK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- uart_in_valid  input  1  producer offers uart_in.
- uart_in  input  DATA_BITS  payload, transmitted LSB first.
- tx_ready  output  1  holding register empty; a transfer occurs when uart_in_valid && tx_ready at a rising edge.
- serial_out  output  1  registered TX line, idle high.
- tx_busy  output  1  a frame is in progress (FSM not IDLE).
- tx_done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Bit period: SAMPLE_TIME = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE, rounded. Default gives 434.
- Elaboration error if SAMPLE_TIME < 2, DATA_BITS is outside 5..9, PARITY > 2, or STOP_BITS is not 1 or 2.
- Baud counter is CNT_WIDTH = $clog2(SAMPLE_TIME) bits. It is cleared on every entry to START, so it is phase-locked to the frame, not free-running.
- bit_edge is asserted when cnt == SAMPLE_TIME-1. Every bit, including each stop bit, lasts exactly SAMPLE_TIME cycles.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * SAMPLE_TIME cycles.
- Reset values: serial_out = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, FSM = IDLE, hold empty, counters 0.
- Reset mid-frame aborts the frame. serial_out is high from the reset edge onward, and held data is discarded.
- Holding register:
  - On a handshake edge, hold <= uart_in and hold_full <= 1; tx_ready = !hold_full.
  - If uart_in_valid is asserted while tx_ready = 0, it is ignored. The producer must hold the data.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if hold_full, then shifter <= hold, clear hold_full, go to START, serial_out <= 0.
  - START: on bit_edge, go to DATA with bit_cnt = 0; serial_out <= shifter[0].
  - DATA: on bit_edge, shift right and increment bit_cnt. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: line carries ^data for even parity, ~^data for odd parity, computed over the DATA_BITS bits of the loaded word. On bit_edge, go to STOP.
  - STOP: line high for STOP_BITS bit periods. On the final bit_edge, tx_done is pulsed for one cycle. Then:
    - if hold_full, go directly to START (reload shifter, serial_out <= 0, no idle cycle);
    - else go to IDLE.
- Simultaneous events: a handshake in the same edge as the STOP-to-START reload is legal. The reload takes the old hold contents and the hold is refilled with the new word, so tx_ready stays 0.
- Latency: handshake at edge k with FSM IDLE → hold full after k → START and serial_out = 0 after edge k+1.
- tx_busy = (state != IDLE).
- serial_out is a flop, so there are no decode glitches on the pin.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants;
  - the state encoding for IDLE..STOP;
  - function calc_sample_time(clock_freq, baud_rate);
  - the legal DATA_BITS bounds.
  These are shared with the future uart_rx_cfg.
- Sub-module uart_baud_gen (params SAMPLE_TIME; ports clk, rst, clear, bit_edge): the counter with synchronous clear. It will be reused by RX with a half-period option added later.

Test Plan (CLOCK_FREQ = 1_000_000, BAUD_RATE = 100_000, so SAMPLE_TIME = 10, unless noted):
- 8N1: send 0xA5 → line 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles; tx_done pulses at cycle 100 after START entry; tx_ready = 1 after the hold empties.
- 7E2 (DATA_BITS=7, PARITY=2, STOP_BITS=2): send 0x53 → 7 data bits LSB first, parity 0, two stop bits; frame 110 cycles. Then 7O1: parity 1, frame 100 cycles.
- Back-to-back: offer 0x01 then 0x02 with valid held high → second handshake occurs while the first frame is active; STOP of frame 1 is followed immediately by START of frame 2 with no idle cycle; tx_ready low while hold is full.
- Backpressure: keep valid high with 3 words → exactly 3 handshakes and 3 frames, in order, with no duplicated or dropped word.
- Reset mid-frame: assert rst during DATA bit 3 → serial_out = 1, tx_busy = 0, tx_ready = 1 on the following cycle; a new word afterwards produces a clean full frame.
- Defaults (50 MHz / 115200): bit width measured as 434 cycles; 9-bit mode sends 0x1FF with all nine data bits = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM encoding, bit-period helper.
// Intended for reuse by the matching receiver.
package uart_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_ODD    = 1;
    localparam int PARITY_EVEN   = 2;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Clock cycles per bit, rounded to nearest.
    function automatic int calc_sample_time(input int clock_freq, input int baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter; bit_edge marks the last cycle of each bit.
// A synchronous clear re-phases the counter to the start of a frame.
module uart_baud_gen #(
    parameter int SAMPLE_TIME = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_edge
);

    localparam int CNT_W = $clog2(SAMPLE_TIME);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_edge = (cnt_q == CNT_W'(SAMPLE_TIME - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_edge) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register so a
// queued word follows the current frame's stop bit with no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_in_valid,
    input  logic [DATA_BITS-1:0] uart_in,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int SAMPLE_TIME = calc_sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int BIT_W       = $clog2(DATA_BITS);

    if (SAMPLE_TIME < 2) begin : g_bad_rate
        $error("uart_tx_cfg: SAMPLE_TIME must be at least 2");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_width
        $error("uart_tx_cfg: DATA_BITS out of range");
    end
    if (PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: illegal PARITY mode");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 hold_full_q, hold_full_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic                 load, handshake, bit_edge, baud_clear;

    assign tx_ready   = !hold_full_q;
    assign handshake  = uart_in_valid && tx_ready;
    assign serial_out = serial_q;
    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_done    = done_q;
    assign baud_clear = (state_q == ST_IDLE) || load;

    uart_baud_gen #(
        .SAMPLE_TIME(SAMPLE_TIME)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_edge(bit_edge)
    );

    // A reload and a refill on the same edge leave the hold full.
    assign hold_d      = handshake ? uart_in : hold_q;
    assign hold_full_d = (hold_full_q && !load) || handshake;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        serial_d   = serial_q;
        done_d     = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                if (hold_full_q) load = 1'b1;
            end
            ST_START: begin
                if (bit_edge) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    serial_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_edge) begin
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
                        if (PARITY != PARITY_NONE) begin
                            state_d  = ST_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = ST_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        serial_d  = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_edge) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                    serial_d   = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_edge) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        if (hold_full_q) load = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d  = ST_START;
            shift_d  = hold_q;
            par_d    = (PARITY == PARITY_ODD) ? ~^hold_q : ^hold_q;
            serial_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            par_q       <= 1'b0;
            serial_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            par_q       <= par_d;
            serial_q    <= serial_d;
            done_q      <= done_d;
        end
    end

endmodule
